// File: rtl/posit_addsub_scheduler.sv
// posit_addsub_scheduler
// Shares one posit add/subtract datapath between two requesters. A round-robin
// arbiter accepts one operand pair at a time, turns A-B into A+(-B) by posit
// negation of B, holds the datapath operands for LAT cycles, captures the
// result and returns it to the owning requester.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   req_valid/req_ready  per-requester request handshake (bit i = requester i)
//   req_a/req_b/req_sub  packed operands (requester i at [i*N +: N]), 1 = subtract
//   rsp_valid/rsp_ready  per-requester response handshake
//   rsp_result           result word shared by both requesters
//   dp_a/dp_b/dp_result  shared datapath operands (dp_b already negated) and result
//   busy                 high whenever an operation is in flight
//
// Optional: define POSIT_SCHED_STATS_EN to add stat_ops0, stat_ops1 and
// stat_nar, 32-bit saturating counters updated on each response handshake.
module posit_addsub_scheduler #(
  parameter int unsigned N   = 32,
  parameter int unsigned ES  = 2,
  parameter int unsigned LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*N-1:0] req_a,
  input  logic [2*N-1:0] req_b,
  input  logic [1:0]     req_sub,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [N-1:0]   rsp_result,
  output logic [N-1:0]   dp_a,
  output logic [N-1:0]   dp_b,
  input  logic [N-1:0]   dp_result,
`ifdef POSIT_SCHED_STATS_EN
  output logic [31:0]    stat_ops0,
  output logic [31:0]    stat_ops1,
  output logic [31:0]    stat_nar,
`endif
  output logic           busy
);

  // ES only matters to the datapath; it is range-checked here so that a bad
  // configuration is caught at elaboration.
  if (LAT < 1 || LAT > 15) begin : g_lat_chk
    $error("LAT must be in 1..15");
  end
  if (ES >= N) begin : g_es_chk
    $error("ES must be smaller than N");
  end

  localparam logic [3:0] LatCnt = 4'(LAT);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           owner_q, owner_d;
  logic           last_grant_q, last_grant_d;
  logic [N-1:0]   dp_a_q, dp_a_d;
  logic [N-1:0]   dp_b_q, dp_b_d;
  logic [N-1:0]   rsp_result_q, rsp_result_d;

  logic           grant;
  logic [N-1:0]   sel_a, sel_b, neg_b;
  logic           sel_sub;
  logic           req_hs, rsp_hs;

  // Tie goes to the requester that was not served last.
  assign grant   = (&req_valid) ? ~last_grant_q : req_valid[1];
  assign sel_a   = grant ? req_a[2*N-1:N] : req_a[N-1:0];
  assign sel_b   = grant ? req_b[2*N-1:N] : req_b[N-1:0];
  assign sel_sub = grant ? req_sub[1] : req_sub[0];
  // Whole-word two's complement; zero and NaR map to themselves naturally.
  assign neg_b   = ~sel_b + {{(N-1){1'b0}}, 1'b1};

  // rst gating keeps req_ready at its reset value while reset is asserted.
  always_comb begin
    req_ready = 2'b00;
    if (state_q == StIdle && !rst) begin
      if (grant) req_ready = {req_valid[1], 1'b0};
      else       req_ready = {1'b0, req_valid[0]};
    end
  end

  assign req_hs    = |(req_valid & req_ready);
  assign rsp_valid = (state_q == StResp) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_hs    = (state_q == StResp) && (owner_q ? rsp_ready[1] : rsp_ready[0]);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    dp_a_d       = dp_a_q;
    dp_b_d       = dp_b_q;
    rsp_result_d = rsp_result_q;
    case (state_q)
      StIdle: begin
        if (req_hs) begin
          dp_a_d  = sel_a;
          dp_b_d  = sel_sub ? neg_b : sel_b;
          owner_d = grant;
          cnt_d   = LatCnt;
          state_d = StExec;
        end
      end
      StExec: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rsp_result_d = dp_result;
          state_d      = StResp;
        end
      end
      StResp: begin
        if (rsp_hs) begin
          last_grant_d = owner_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      dp_a_q       <= '0;
      dp_b_q       <= '0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      dp_a_q       <= dp_a_d;
      dp_b_q       <= dp_b_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign dp_a       = dp_a_q;
  assign dp_b       = dp_b_q;
  assign rsp_result = rsp_result_q;
  assign busy       = (state_q != StIdle);

`ifdef POSIT_SCHED_STATS_EN
  logic [31:0] stat_ops0_q, stat_ops0_d;
  logic [31:0] stat_ops1_q, stat_ops1_d;
  logic [31:0] stat_nar_q, stat_nar_d;
  logic        rsp_is_nar;

  assign rsp_is_nar = (rsp_result_q == {1'b1, {(N-1){1'b0}}});

  always_comb begin
    stat_ops0_d = stat_ops0_q;
    stat_ops1_d = stat_ops1_q;
    stat_nar_d  = stat_nar_q;
    if (rsp_hs) begin
      if (!owner_q && !(&stat_ops0_q)) stat_ops0_d = stat_ops0_q + 32'd1;
      if (owner_q && !(&stat_ops1_q))  stat_ops1_d = stat_ops1_q + 32'd1;
      if (rsp_is_nar && !(&stat_nar_q)) stat_nar_d = stat_nar_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops0_q <= 32'd0;
      stat_ops1_q <= 32'd0;
      stat_nar_q  <= 32'd0;
    end else begin
      stat_ops0_q <= stat_ops0_d;
      stat_ops1_q <= stat_ops1_d;
      stat_nar_q  <= stat_nar_d;
    end
  end

  assign stat_ops0 = stat_ops0_q;
  assign stat_ops1 = stat_ops1_q;
  assign stat_nar  = stat_nar_q;
`endif

endmodule
